// File: rtl/shift_pkg.sv
// Shared encodings for the shift sequencer and the ALU control decoder:
// FSM states, shifter command codes and request op codes.
package shift_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic [2:0] CMD_NOP  = 3'b000;
    localparam logic [2:0] CMD_LOAD = 3'b001;
    localparam logic [2:0] CMD_SHL  = 3'b010;
    localparam logic [2:0] CMD_SHR  = 3'b011;
    localparam logic [2:0] CMD_SRA  = 3'b100;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_LUI = 2'b11;

    // Shift command issued for a request op; LUI is a left shift of the immediate.
    function automatic logic [2:0] shift_cmd(input logic [1:0] op);
        case (op)
            OP_SRL:  return CMD_SHR;
            OP_SRA:  return CMD_SRA;
            default: return CMD_SHL;
        endcase
    endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Multi-cycle controller for RegDesloc: turns one shift request into a
// load command, one or more chunked shift commands and a done strobe.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int MAX_STEP   = 31,
    parameter int LUI_AMOUNT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [4:0] shamt,
    output logic       busy,
    output logic       done,
    output logic [2:0] shifter_control,
    output logic [4:0] shifter_n,
    output logic       m_shifter,
    output logic       result_we
);

    localparam logic [4:0] MAX_STEP_U = 5'(MAX_STEP);
    localparam logic [4:0] LUI_AMT_U  = 5'(LUI_AMOUNT);

    // Distance for the next shift command: never more than what is left,
    // so the remaining count cannot underflow.
    function automatic logic [4:0] step_of(input logic [4:0] r);
        return (r < MAX_STEP_U) ? r : MAX_STEP_U;
    endfunction

    state_t     state_q;
    state_t     state_nxt;
    logic [1:0] op_q;
    logic [4:0] rem_q;
    logic       m_shifter_q;
    logic [4:0] step;
    logic [4:0] rem_after;

    assign step      = step_of(rem_q);
    assign rem_after = rem_q - step;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_nxt;
    end

    // Request latch and remaining-distance counter; source select held until IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= OP_SLL;
            rem_q       <= 5'd0;
            m_shifter_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        rem_q       <= (op == OP_LUI) ? LUI_AMT_U : shamt;
                        m_shifter_q <= (op == OP_LUI);
                    end
                end
                ST_SHIFT: rem_q       <= rem_after;
                ST_DONE:  m_shifter_q <= 1'b0;
                default:  ;
            endcase
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = (rem_q != 5'd0) ? ST_SHIFT : ST_DONE;
            ST_SHIFT: state_nxt = (rem_after != 5'd0) ? ST_SHIFT : ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Moore output decode from registered state, op and remaining count.
    always_comb begin
        busy            = 1'b0;
        done            = 1'b0;
        shifter_control = CMD_NOP;
        shifter_n       = 5'd0;
        case (state_q)
            ST_LOAD: begin
                busy            = 1'b1;
                shifter_control = CMD_LOAD;
            end
            ST_SHIFT: begin
                busy            = 1'b1;
                shifter_control = shift_cmd(op_q);
                shifter_n       = step;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign m_shifter = m_shifter_q;
    assign result_we = done;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: three instances (MAX_STEP 31, 3, 4) share the
// clock and reset; a behavioural RegDesloc follows each command stream.
module tb_shift_sequencer;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [2:0] ctrl;
        logic [4:0] n;
        logic       m;
        logic       we;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_i [3];
    logic [1:0] op_i    [3];
    logic [4:0] shamt_i [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic [2:0] ctrl_w  [3];
    logic [4:0] n_w     [3];
    logic       m_w     [3];
    logic       we_w    [3];

    logic [31:0] reg_v [3];
    logic [31:0] imm_v [3];
    logic [31:0] sh    [3];

    obs_t        exp_q[$];
    logic [31:0] res_q[$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        shift_sequencer #(
            .MAX_STEP  ((g == 0) ? 31 : ((g == 1) ? 3 : 4)),
            .LUI_AMOUNT(16)
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .start          (start_i[g]),
            .op             (op_i[g]),
            .shamt          (shamt_i[g]),
            .busy           (busy_w[g]),
            .done           (done_w[g]),
            .shifter_control(ctrl_w[g]),
            .shifter_n      (n_w[g]),
            .m_shifter      (m_w[g]),
            .result_we      (we_w[g])
        );
    end

    // Behavioural shift register driven by each sequencer's commands.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            case (ctrl_w[k])
                3'b001:  sh[k] <= m_w[k] ? imm_v[k] : reg_v[k];
                3'b010:  sh[k] <= sh[k] << n_w[k];
                3'b011:  sh[k] <= sh[k] >> n_w[k];
                3'b100:  sh[k] <= $unsigned($signed(sh[k]) >>> n_w[k]);
                default: sh[k] <= sh[k];
            endcase
        end
    end

    function automatic int ms_of(input int i);
        return (i == 0) ? 31 : ((i == 1) ? 3 : 4);
    endfunction

    function automatic obs_t get(input int i);
        return obs_t'({busy_w[i], done_w[i], ctrl_w[i], n_w[i], m_w[i], we_w[i]});
    endfunction

    // Expected per-cycle outputs for one request, from LOAD to the first IDLE cycle.
    task automatic push_model(input int i, input logic [1:0] o, input logic [4:0] s);
        int   left;
        int   stp;
        logic lui;
        logic [2:0] cmd;
        lui  = (o == 2'b11);
        left = lui ? 16 : int'(s);
        cmd  = (o == 2'b01) ? 3'b011 : ((o == 2'b10) ? 3'b100 : 3'b010);
        exp_q.push_back(obs_t'({1'b1, 1'b0, 3'b001, 5'd0, lui, 1'b0}));
        while (left > 0) begin
            stp  = (left > ms_of(i)) ? ms_of(i) : left;
            exp_q.push_back(obs_t'({1'b1, 1'b0, cmd, 5'(stp), lui, 1'b0}));
            left = left - stp;
        end
        exp_q.push_back(obs_t'({1'b1, 1'b1, 3'b000, 5'd0, lui, 1'b1}));
        exp_q.push_back(obs_t'(12'd0));
    endtask

    // Compare outputs cycle by cycle until the expected stream is exhausted;
    // poke bit c re-asserts start (with po/ps) after observing cycle c.
    task automatic drain(input int i, input logic [15:0] poke,
                         input logic [1:0] po, input logic [4:0] ps);
        int          c = 0;
        obs_t        e;
        obs_t        a;
        logic [31:0] r;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            c++;
            if (c > 40) begin
                tests++; fails++;
                $display("FAIL timeout inst%0d: %0d expected cycles never observed", i, exp_q.size());
                exp_q.delete();
                res_q.delete();
                break;
            end
            e = exp_q.pop_front();
            a = get(i);
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL seq inst%0d cycle %0d: got busy=%b done=%b ctrl=%b n=%0d m=%b we=%b, want busy=%b done=%b ctrl=%b n=%0d m=%b we=%b",
                         i, c, a.busy, a.done, a.ctrl, a.n, a.m, a.we,
                         e.busy, e.done, e.ctrl, e.n, e.m, e.we);
            end
            if (a.done === 1'b1) begin
                tests++;
                if (res_q.size() == 0) begin
                    fails++;
                    $display("FAIL result inst%0d: unexpected done at cycle %0d", i, c);
                end else begin
                    r = res_q.pop_front();
                    if (sh[i] !== r) begin
                        fails++;
                        $display("FAIL result inst%0d: got %h want %h", i, sh[i], r);
                    end
                end
            end
            if (c < 16 && poke[c]) begin
                start_i[i] = 1'b1; op_i[i] = po; shamt_i[i] = ps;
            end else begin
                start_i[i] = 1'b0;
            end
        end
        if (res_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL result inst%0d: %0d results never produced", i, res_q.size());
            res_q.delete();
        end
    endtask

    // Issue a request from a negedge and check its whole sequence.
    task automatic run_req(input int i, input logic [1:0] o, input logic [4:0] s,
                           input logic [31:0] rv, input logic [31:0] iv,
                           input logic [31:0] want,
                           input logic [15:0] poke, input logic [1:0] po, input logic [4:0] ps);
        reg_v[i] = rv; imm_v[i] = iv;
        start_i[i] = 1'b1; op_i[i] = o; shamt_i[i] = s;
        push_model(i, o, s);
        res_q.push_back(want);
        drain(i, poke, po, ps);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (get(k) !== obs_t'(12'd0)) begin
                fails++;
                $display("FAIL reset inst%0d: got %h want 000", k, get(k));
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_sll();
        @(negedge clk);
        run_req(0, 2'b00, 5'd5, 32'h0000_0001, 32'h0, 32'h0000_0020, 16'h0, 2'b00, 5'd0);
    endtask

    task automatic test_sra_chunks();
        @(negedge clk);
        run_req(1, 2'b10, 5'd7, 32'h8000_0000, 32'h0, 32'hFF00_0000, 16'h0, 2'b00, 5'd0);
    endtask

    task automatic test_lui();
        @(negedge clk);
        run_req(0, 2'b11, 5'd9, 32'hDEAD_BEEF, 32'h0000_1234, 32'h1234_0000, 16'h0, 2'b00, 5'd0);
        @(negedge clk);
        run_req(2, 2'b11, 5'd2, 32'h0, 32'h0000_00AB, 32'h00AB_0000, 16'h0, 2'b00, 5'd0);
    endtask

    task automatic test_zero_and_max();
        @(negedge clk);
        run_req(0, 2'b01, 5'd0, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 16'h0, 2'b00, 5'd0);
        @(negedge clk);
        run_req(0, 2'b00, 5'd31, 32'h0000_0003, 32'h0, 32'h8000_0000, 16'h0, 2'b00, 5'd0);
        @(negedge clk);
        run_req(1, 2'b01, 5'd31, 32'hFFFF_FFFF, 32'h0, 32'h0000_0001, 16'h0, 2'b00, 5'd0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        // Starts during SHIFT (cycle 2) and DONE (cycle 3) must be dropped.
        run_req(0, 2'b00, 5'd5, 32'h0000_0003, 32'h0, 32'h0000_0060, 16'h000C, 2'b10, 5'd3);
        // Immediately in the first IDLE cycle: accepted.
        run_req(0, 2'b10, 5'd3, 32'h8000_0010, 32'h0, 32'hF000_0002, 16'h0, 2'b00, 5'd0);
    endtask

    task automatic test_reset_mid();
        obs_t e;
        @(negedge clk);
        reg_v[2] = 32'hF000_0000; imm_v[2] = 32'h0;
        start_i[2] = 1'b1; op_i[2] = 2'b01; shamt_i[2] = 5'd20;
        push_model(2, 2'b01, 5'd20);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start_i[2] = 1'b0;
            e = exp_q.pop_front();
            tests++;
            if (get(2) !== e) begin
                fails++;
                $display("FAIL midrst pre cycle %0d: got %h want %h", c, get(2), e);
            end
        end
        exp_q.delete();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (get(2) !== obs_t'(12'd0)) begin
            fails++;
            $display("FAIL midrst abort: got %h want 000", get(2));
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (get(2) !== obs_t'(12'd0)) begin
                fails++;
                $display("FAIL midrst idle %0d: got %h want 000", c, get(2));
            end
        end
        run_req(2, 2'b01, 5'd20, 32'hF000_0000, 32'h0, 32'h0000_0F00, 16'h0, 2'b00, 5'd0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            start_i[k] = 1'b0; op_i[k] = 2'b00; shamt_i[k] = 5'd0;
            reg_v[k] = 32'h0; imm_v[k] = 32'h0;
        end
        test_reset();
        test_sll();
        test_sra_chunks();
        test_lui();
        test_zero_and_max();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller for the processor's shift register (RegDesloc). Takes one shift request from the main control unit and sequences it as a load command, then one or more shift commands, then a one-cycle completion strobe.
- Splits large shift amounts into chunks of at most MAX_STEP bits per cycle, so the control unit never tracks shifter cycles itself.
- Sits between the control unit and RegDesloc. Also drives the shifter-source mux (M_SHIFTER) and the ALUOut write enable.

Parameters:
- MAX_STEP, 31, maximum shift distance issued per shift command (legal range 1..31; 1 gives bit-serial operation).
- LUI_AMOUNT, 16, shift distance forced for LUI requests.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only when idle (busy=0)
- op  input  2  00=SLL, 01=SRL, 10=SRA, 11=LUI
- shamt  input  5  shift amount; ignored for LUI
- busy  output  1  high from the cycle after an accepted start through the DONE cycle inclusive
- done  output  1  one-cycle pulse when the shifter result is valid
- shifter_control  output  3  000=nop, 001=load, 010=shift left, 011=shift right logical, 100=shift right arithmetic
- shifter_n  output  5  shift distance applied with the current shift command
- m_shifter  output  1  shifter source select: 0=register operand, 1=immediate (LUI)
- result_we  output  1  ALUOut load enable; equal to done

Behaviour:
- Reset: sync reset forces state IDLE and clears the latched op, remaining count and m_shifter. All outputs are 0 in the cycle after reset is sampled high. Reset mid-operation aborts immediately; there is no done pulse.
- Latched registers:
  - op_q (2 bits) and rem (5 bits) are loaded on an accepted start.
  - For LUI, rem is loaded with LUI_AMOUNT, otherwise with shamt.
  - m_shifter is registered: it is set to 1 on LUI acceptance and held until the return to IDLE.
- IDLE:
  - busy=0, shifter_control=000.
  - start=1 at an edge moves to LOAD; start=0 stays in IDLE.
- LOAD (exactly 1 cycle):
  - busy=1, shifter_control=001, shifter_n=0.
  - Next state is SHIFT if rem!=0, otherwise DONE.
- SHIFT:
  - busy=1.
  - shifter_control is the command for op_q: SLL and LUI give 010, SRL gives 011, SRA gives 100.
  - shifter_n = min(rem, MAX_STEP).
  - At the edge, rem <= rem - shifter_n. Stay in SHIFT while the new rem != 0; otherwise go to DONE.
- DONE (exactly 1 cycle):
  - busy=1, done=1, result_we=1, shifter_control=000.
  - Next state is IDLE unconditionally.
- Outputs are Moore: decoded from the registered state, op_q and rem only. There are no combinational paths from start, op or shamt to any output.
- Latency: from the edge sampling start to the done cycle = 1 (LOAD) + ceil(S/MAX_STEP) (SHIFT) + 1 (DONE) cycles, where S is the effective shift amount.
- Back-to-back requests:
  - start while busy=1 is ignored and not queued.
  - start high during the DONE cycle is also ignored, because the block is not yet IDLE.
  - The earliest new acceptance is the edge ending the first IDLE cycle after DONE.
- Arithmetic:
  - rem is unsigned 5 bits and never underflows, because shifter_n <= rem.
  - MAX_STEP is compared zero-extended to 5 bits.
- Boundary cases:
  - shamt=0: LOAD then DONE, with no shift command issued.
  - shamt=31 with MAX_STEP=31: a single SHIFT cycle.
  - Any op/shamt change while busy has no effect.
- Unused op encodings: none, since all four 2-bit codes are defined.

Decomposition:
- Shared package (shift_pkg) holds:
  - state encoding localparams (IDLE, LOAD, SHIFT, DONE);
  - shifter command codes (NOP, LOAD, SHL, SHR, SRA);
  - request op codes (SLL, SRL, SRA, LUI).
- The same shifter command codes are used by the ALU control decoder, so both blocks stay consistent.
- No sub-module: the step counter and FSM fit in one module (~150-200 lines).

Test Plan:
- SLL, shamt=5, MAX_STEP=31:
  - start at edge 0 gives LOAD (001) at cycle 1, SHIFT 010 with n=5 at cycle 2, done=1 at cycle 3, busy low at cycle 4.
- SRA, shamt=7, MAX_STEP=3:
  - SHIFT cycles issue 100 with n=3, 3, 1; done at cycle 5.
  - Result for a 0x80000000 operand is 0xFF000000.
- LUI with shamt input = 9:
  - m_shifter=1 from cycle 1 through done; a single shift of n=16 (010).
  - Immediate 0x1234 yields 0x12340000.
- SRL, shamt=0:
  - LOAD at cycle 1, done at cycle 2, and shifter_control never equals 011.
- start pulsed during SHIFT and during DONE:
  - Both requests are ignored, with one done pulse only.
  - A start in the following IDLE cycle is accepted normally.
- reset asserted during the second SHIFT cycle of the SRL shamt=20 / MAX_STEP=4 case:
  - Next cycle has all outputs 0 and state IDLE, with no done pulse.
  - A fresh request then completes normally.
